// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared constants, hex font table and scan state type
package seven_seg_pkg;

   localparam int SEG_A = 0;
   localparam int SEG_B = 1;
   localparam int SEG_C = 2;
   localparam int SEG_D = 3;
   localparam int SEG_E = 4;
   localparam int SEG_F = 5;
   localparam int SEG_G = 6;

   // Active-high pattern for an unlit digit; the top applies pin polarity.
   localparam logic [6:0] SEG_BLANK = 7'h00;

   localparam logic [6:0] HEX_FONT [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   typedef enum logic {ST_BLANK, ST_DRIVE} state_e;

endpackage

// File: rtl/seven_seg_hex_font.sv
// rtl/seven_seg_hex_font.sv - hex nibble to active-high segment pattern (g..a)
module seven_seg_hex_font
   import seven_seg_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   assign seg = HEX_FONT[nibble];

endmodule

// File: rtl/seven_seg_mux_driver.sv
// rtl/seven_seg_mux_driver.sv - double-buffered, blanked, multiplexed N-digit driver
// Define LEADING_ZERO_SUPPRESS_EN to darken leading zero digits above digit 0.
module seven_seg_mux_driver
   import seven_seg_pkg::*;
#(
   parameter int NUM_DIGITS     = 4,
   parameter int REFRESH_DIV    = 1000,
   parameter int BLANK_CYCLES   = 16,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int AN_ACTIVE_LOW  = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   digit_en,
   input  logic                    load,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame_tick
);

   localparam int CNT_W = $clog2(REFRESH_DIV);
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
   localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(NUM_DIGITS - 1);
   localparam logic [6:0] SEG_INV = {7{SEG_ACTIVE_LOW != 0}};
   localparam logic [6:0] SEG_OFF = SEG_BLANK ^ SEG_INV;
   localparam logic       DP_OFF  = (SEG_ACTIVE_LOW != 0);
   localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{AN_ACTIVE_LOW != 0}};

   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   state_e                  state_q, state_d;
   logic [4*NUM_DIGITS-1:0] shadow_val_q, shadow_val_d, disp_val_q, disp_val_d;
   logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d, disp_dp_q, disp_dp_d;
   logic                    pending_q, pending_d;
   logic [6:0]              seg_q, seg_d;
   logic                    dp_q, dp_d;
   logic [NUM_DIGITS-1:0]   an_q, an_d;
   logic                    frame_tick_q, frame_tick_d;

   logic                    cnt_wrap, frame_bound;
   logic [3:0]              nibble;
   logic [6:0]              font_seg;
   logic [NUM_DIGITS-1:0]   show_en;

   always_comb begin
      cnt_wrap     = (cnt_q == CNT_MAX);
      frame_bound  = cnt_wrap && (idx_q == IDX_MAX);
      cnt_d        = cnt_wrap ? '0 : cnt_q + 1'b1;
      idx_d        = idx_q;
      if (cnt_wrap) idx_d = frame_bound ? '0 : idx_q + 1'b1;
      shadow_val_d = load ? value : shadow_val_q;
      shadow_dp_d  = load ? dp_in : shadow_dp_q;
      disp_val_d   = disp_val_q;
      disp_dp_d    = disp_dp_q;
      pending_d    = pending_q;
      // Display copies the pre-write shadow; a coincident load keeps pending set.
      if (frame_bound && pending_q) begin
         disp_val_d = shadow_val_q;
         disp_dp_d  = shadow_dp_q;
         pending_d  = 1'b0;
      end
      if (load) pending_d = 1'b1;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_BLANK: if (cnt_d >= CNT_BLANK) state_d = ST_DRIVE;
         ST_DRIVE: if (cnt_d < CNT_BLANK) state_d = ST_BLANK;
         default:  state_d = ST_BLANK;
      endcase
   end

   always_comb begin
      show_en = digit_en;
`ifdef LEADING_ZERO_SUPPRESS_EN
      begin
         logic lz_run;
         lz_run = 1'b1;
         for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            lz_run = lz_run && (disp_val_q[4*k +: 4] == 4'h0);
            if (lz_run && !disp_dp_q[k]) show_en[k] = 1'b0;
         end
      end
`endif
   end

   assign nibble = disp_val_q[4*int'(idx_q) +: 4];

   seven_seg_hex_font u_font (
      .nibble (nibble),
      .seg    (font_seg)
   );

   always_comb begin
      seg_d        = SEG_OFF;
      dp_d         = DP_OFF;
      an_d         = AN_OFF;
      frame_tick_d = frame_bound;
      if (state_q == ST_DRIVE && show_en[idx_q]) begin
         seg_d       = font_seg ^ SEG_INV;
         dp_d        = disp_dp_q[idx_q] ^ DP_OFF;
         an_d[idx_q] = (AN_ACTIVE_LOW == 0);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q        <= '0;
         idx_q        <= '0;
         state_q      <= ST_BLANK;
         shadow_val_q <= '0;
         shadow_dp_q  <= '0;
         disp_val_q   <= '0;
         disp_dp_q    <= '0;
         pending_q    <= 1'b0;
         seg_q        <= SEG_OFF;
         dp_q         <= DP_OFF;
         an_q         <= AN_OFF;
         frame_tick_q <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         state_q      <= state_d;
         shadow_val_q <= shadow_val_d;
         shadow_dp_q  <= shadow_dp_d;
         disp_val_q   <= disp_val_d;
         disp_dp_q    <= disp_dp_d;
         pending_q    <= pending_d;
         seg_q        <= seg_d;
         dp_q         <= dp_d;
         an_q         <= an_d;
         frame_tick_q <= frame_tick_d;
      end
   end

   assign seg        = seg_q;
   assign dp         = dp_q;
   assign an         = an_q;
   assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seven_seg_mux_driver.sv
// tb/tb_seven_seg_mux_driver.sv - directed self-checking bench, 4 digits, 4-cycle slots, 1 blank cycle
module tb_seven_seg_mux_driver;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] value;
   logic [3:0]  dp_in;
   logic [3:0]  digit_en;
   logic        load;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;
   logic        frame_tick;

   int tests_run    = 0;
   int tests_failed = 0;

   localparam logic [6:0] FONT [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

`ifdef LEADING_ZERO_SUPPRESS_EN
   localparam logic [3:0] MASK_ZERO = 4'b0001;
   localparam logic [3:0] MASK_3    = 4'b0001;
   localparam logic [3:0] MASK_70   = 4'b0011;
`else
   localparam logic [3:0] MASK_ZERO = 4'b1111;
   localparam logic [3:0] MASK_3    = 4'b1111;
   localparam logic [3:0] MASK_70   = 4'b1111;
`endif

   seven_seg_mux_driver #(
      .NUM_DIGITS     (4),
      .REFRESH_DIV    (4),
      .BLANK_CYCLES   (1),
      .SEG_ACTIVE_LOW (1),
      .AN_ACTIVE_LOW  (1)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .value      (value),
      .dp_in      (dp_in),
      .digit_en   (digit_en),
      .load       (load),
      .seg        (seg),
      .dp         (dp),
      .an         (an),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_off(input string tag);
      check({tag, " seg"}, 32'(seg), 32'h7F);
      check({tag, " dp"}, 32'(dp), 32'h1);
      check({tag, " an"}, 32'(an), 32'hF);
      check({tag, " tick"}, 32'(frame_tick), 32'h0);
   endtask

   task automatic wait_tick(input string tag);
      logic seen;
      seen = 1'b0;
      for (int n = 0; n < 40 && !seen; n++) begin
         step();
         seen = frame_tick;
      end
      check({tag, " frame_tick seen"}, 32'(seen), 32'h1);
   endtask

   // Step one full frame starting right after a frame_tick; outputs lag the scan by one cycle.
   task automatic check_frame(input string tag, input logic [15:0] val,
                              input logic [3:0] dpv, input logic [3:0] en);
      int         q;
      int         d;
      logic [6:0] e_seg;
      logic       e_dp;
      logic [3:0] e_an;
      for (int j = 1; j <= 16; j++) begin
         step();
         q     = j - 1;
         d     = q / 4;
         e_seg = 7'h7F;
         e_dp  = 1'b1;
         e_an  = 4'hF;
         if ((q % 4) != 0 && en[d]) begin
            e_seg = ~FONT[val[4*d +: 4]];
            e_dp  = ~dpv[d];
            e_an  = ~(4'b0001 << d);
         end
         check($sformatf("%s seg c%0d", tag, j), 32'(seg), 32'(e_seg));
         check($sformatf("%s dp c%0d", tag, j), 32'(dp), 32'(e_dp));
         check($sformatf("%s an c%0d", tag, j), 32'(an), 32'(e_an));
         check($sformatf("%s tick c%0d", tag, j), 32'(frame_tick), 32'(j == 16));
      end
   endtask

   initial begin
      reset    = 1'b1;
      value    = 16'h0000;
      dp_in    = 4'h0;
      digit_en = 4'hF;
      load     = 1'b0;

      repeat (3) begin
         step();
         check_off("reset");
      end
      reset = 1'b0;
      step();
      check_off("post_reset");

      value = 16'h12AF;
      dp_in = 4'b0100;
      load  = 1'b1;
      step();
      load  = 1'b0;
      wait_tick("t2");
      check_frame("t2", 16'h12AF, 4'b0100, 4'hF);

      value = 16'h0003;
      dp_in = 4'h0;
      repeat (3) step();
      check("t4 early seg", 32'(seg), 32'h0E);
      load = 1'b1;
      step();
      load = 1'b0;
      check("t4 after load seg", 32'(seg), 32'h0E);
      repeat (11) step();
      check("t4 late seg", 32'(seg), 32'h79);
      check("t4 late an", 32'(an), 32'h7);
      value = 16'h0005;
      load  = 1'b1;
      step();
      load  = 1'b0;
      check("t4 boundary tick", 32'(frame_tick), 32'h1);
      check("t4 boundary seg", 32'(seg), 32'h79);
      check_frame("t4 next", 16'h0003, 4'h0, MASK_3);
      check_frame("t4 after", 16'h0005, 4'h0, MASK_3);

      digit_en = 4'b1011;
      check_frame("t5 en", 16'h0005, 4'h0, MASK_3 & 4'b1011);
      digit_en = 4'hF;
      value    = 16'h0009;
      load     = 1'b1;
      step();
      load     = 1'b0;
      repeat (5) step();
      reset = 1'b1;
      step();
      check_off("t5 mid reset");
      reset = 1'b0;
      check_frame("t5 restart", 16'h0000, 4'h0, MASK_ZERO);
      check_frame("t5 no pending", 16'h0000, 4'h0, MASK_ZERO);

      value = 16'h0070;
      load  = 1'b1;
      step();
      load  = 1'b0;
      wait_tick("t6");
      check_frame("t6", 16'h0070, 4'h0, MASK_70);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
